i2c_master_ctrl: RTL and testbench

Parametrised single-master I2C controller that turns one command (7-bit address, direction, byte count) into a complete bus transaction: START, address+R/W, per-byte ACK handling, multi-byte write or read, STOP. Generates real SCL timing from a programmable divider, drives both lines open-drain, samples slave ACK/NACK, and supports slave clock stretching. Sits between a register/command front-end and the board-level I2C pads.

---
 rtl/i2c_master_ctrl.sv | 172 +++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-master I2C transaction controller with clock stretching
module i2c_master_ctrl #(
    parameter int QDIV = 4,
    parameter int NB_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [6:0]      addr,
    input  logic            rw,
    input  logic [NB_W-1:0] nbytes,
    input  logic [7:0]      wr_data,
    output logic            wr_req,
    output logic [7:0]      rd_data,
    output logic            rd_valid,
    output logic            busy,
    output logic            done,
    output logic            nack,
    output logic            scl_oe,
    output logic            sda_oe,
    input  logic            scl_in,
    input  logic            sda_in
);

    localparam int QW = $clog2(QDIV);
    localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
    } state_t;

    state_t            state, state_nx;
    logic [QW-1:0]     qcnt;
    logic [1:0]        ph;
    logic [2:0]        bit_cnt;
    logic [7:0]        tx_sr;
    logic [6:0]        rx_sr;
    logic              rw_q;
    logic [NB_W-1:0]   nb_cnt;
    logic              bit_state, stretch, phase_end, bit_end, byte_end, accept;

    assign busy = (state != S_IDLE);

    // Phase timing: a phase ends after QDIV clocks; SCL-high phase P2 freezes while a slave stretches
    always_comb begin
        bit_state = (state == S_ADDR) || (state == S_AACK) || (state == S_WDATA) ||
                    (state == S_WACK) || (state == S_RDATA) || (state == S_RACK);
        stretch   = bit_state && (ph == 2'd2) && !scl_in;
        phase_end = (qcnt == QMAX) && !stretch;
        bit_end   = bit_state && phase_end && (ph == 2'd3);
        byte_end  = bit_end && (bit_cnt == 3'd7);
        // a start arriving while done pulses belongs to the old transaction and is dropped
        accept    = (state == S_IDLE) && start && !done;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and line/handshake outputs
    always_comb begin
        state_nx = state;
        scl_oe   = 1'b0;
        sda_oe   = 1'b0;
        wr_req   = 1'b0;
        if (bit_state) scl_oe = !ph[1];
        case (state)
            S_IDLE:  if (accept) state_nx = S_START;
            S_START: begin
                sda_oe = (ph == 2'd1);
                if (phase_end && ph == 2'd1) state_nx = S_ADDR;
            end
            S_ADDR: begin
                sda_oe = !tx_sr[7];
                if (byte_end) state_nx = S_AACK;
            end
            S_AACK: begin
                if (bit_end) begin
                    if (sda_in || nb_cnt == '0) state_nx = S_STOP;
                    else if (rw_q)              state_nx = S_RDATA;
                    else begin
                        state_nx = S_WDATA;
                        wr_req   = 1'b1;
                    end
                end
            end
            S_WDATA: begin
                sda_oe = !tx_sr[7];
                if (byte_end) state_nx = S_WACK;
            end
            S_WACK: begin
                if (bit_end) begin
                    if (sda_in || nb_cnt == '0) state_nx = S_STOP;
                    else begin
                        state_nx = S_WDATA;
                        wr_req   = 1'b1;
                    end
                end
            end
            S_RDATA: if (byte_end) state_nx = S_RACK;
            S_RACK: begin
                // ACK keeps the slave sending; releasing SDA on the final byte is the NACK
                sda_oe = (nb_cnt != '0);
                if (bit_end) state_nx = (nb_cnt != '0) ? S_RDATA : S_STOP;
            end
            S_STOP: begin
                scl_oe = (ph == 2'd0);
                sda_oe = (ph != 2'd2);
                if (phase_end && ph == 2'd2) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Quarter-period, phase and bit counters; restart from zero on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qcnt    <= '0;
            ph      <= 2'd0;
            bit_cnt <= 3'd0;
        end else if (state_nx != state) begin
            qcnt    <= '0;
            ph      <= 2'd0;
            bit_cnt <= 3'd0;
        end else if (state != S_IDLE) begin
            if (phase_end) begin
                qcnt <= '0;
                ph   <= ph + 2'd1;
                if (ph == 2'd3) bit_cnt <= bit_cnt + 3'd1;
            end else if (!stretch) begin
                qcnt <= qcnt + QW'(1);
            end
        end
    end

    // Command latch, shift registers, byte counter and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sr    <= 8'h00;
            rx_sr    <= 7'h00;
            rw_q     <= 1'b0;
            nb_cnt   <= '0;
            nack     <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= (state == S_STOP) && phase_end && (ph == 2'd2);
            if (accept) begin
                tx_sr  <= {addr, rw};
                rw_q   <= rw;
                nb_cnt <= nbytes;
                nack   <= 1'b0;
            end else if (wr_req) begin
                tx_sr <= wr_data;
            end else if (bit_end && (state == S_ADDR || state == S_WDATA)) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (bit_end && state == S_RDATA) rx_sr <= {rx_sr[5:0], sda_in};
            if (byte_end && state == S_RDATA) begin
                rd_data  <= {rx_sr, sda_in};
                rd_valid <= 1'b1;
            end
            if (byte_end && (state == S_WDATA || state == S_RDATA)) nb_cnt <= nb_cnt - 1'b1;
            if (bit_end && (state == S_AACK || state == S_WACK) && sda_in) nack <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - directed bench for i2c_master_ctrl with a bit-level slave model
module tb_i2c_master_ctrl;

    localparam int QDIV = 4;
    localparam int NB_W = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [6:0]      addr = 7'h00;
    logic            rw = 1'b0;
    logic [NB_W-1:0] nbytes = '0;
    logic [7:0]      wr_data = 8'h00;
    logic            wr_req, rd_valid, busy, done, nack, scl_oe, sda_oe;
    logic [7:0]      rd_data;
    logic            scl_in, sda_in;

    // slave model controls
    logic            ack_addr = 1'b1;
    logic            ack_data = 1'b1;
    logic            stretch_en = 1'b0;
    int              nrd = 0;
    logic [7:0]      rd_bytes [0:3];

    // slave / monitor state
    logic            sda_low = 1'b0;
    int              hold_cnt = 0;
    logic            prev_scl = 1'b1;
    logic            prev_sda = 1'b1;
    int              bitn = 0;
    logic            slave_rd = 1'b0;
    logic [8:0]      frames [0:7];
    int              n_start = 0;
    int              n_stop = 0;
    int              wr_cnt = 0;
    int              rd_cnt = 0;
    logic [7:0]      rd_log [0:15];

    int              n_tests = 0;
    int              n_fail = 0;

    assign scl_in = !scl_oe && (hold_cnt == 0);
    assign sda_in = !sda_oe && !sda_low;

    i2c_master_ctrl #(.QDIV(QDIV), .NB_W(NB_W)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw),
        .nbytes(nbytes), .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .nack(nack),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    // Bus monitor and slave: records each 9-bit frame on SCL rise, drives SDA on SCL fall
    always @(negedge clk) begin
        if (reset) begin
            sda_low  <= 1'b0;
            hold_cnt <= 0;
            prev_scl <= 1'b1;
            prev_sda <= 1'b1;
            bitn     <= 0;
            slave_rd <= 1'b0;
        end else begin
            if (hold_cnt != 0) hold_cnt <= hold_cnt - 1;
            if (prev_scl && scl_in && prev_sda && !sda_in) begin
                n_start <= n_start + 1;
                bitn    <= 0;
            end
            if (prev_scl && scl_in && !prev_sda && sda_in) n_stop <= n_stop + 1;
            if (!prev_scl && scl_in) begin
                if (bitn < 72) frames[bitn / 9][8 - (bitn % 9)] <= sda_in;
                if (bitn == 7) slave_rd <= sda_in;
                bitn <= bitn + 1;
            end
            if (prev_scl && !scl_in) begin
                if (bitn % 9 == 8)
                    sda_low <= (bitn / 9 == 0) ? ack_addr : (!slave_rd && ack_data);
                else if (slave_rd && bitn / 9 >= 1 && bitn / 9 <= nrd)
                    sda_low <= !rd_bytes[bitn / 9 - 1][7 - (bitn % 9)];
                else
                    sda_low <= 1'b0;
                if (stretch_en && bitn == 3) hold_cnt <= 2 * QDIV + 20;
            end
            if (wr_req) wr_cnt <= wr_cnt + 1;
            if (rd_valid) begin
                rd_log[rd_cnt % 16] <= rd_data;
                rd_cnt <= rd_cnt + 1;
            end
            prev_scl <= scl_in;
            prev_sda <= sda_in;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command and count clocks until done; abort_at>0 stops early, poke re-strobes while busy
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [NB_W-1:0] nb,
                           input int abort_at, input bit poke, output int cyc);
        @(negedge clk);
        addr = a; rw = r; nbytes = nb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3000 && !(abort_at != 0 && cyc >= abort_at)) begin
            if (poke && cyc == 10) begin
                start = 1'b1; addr = 7'h11; rw = 1'b1; nbytes = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc, s0, p0, w0, r0;
        rd_bytes[0] = 8'h3C; rd_bytes[1] = 8'hC3; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_scl_oe", scl_oe, 0);
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_nack", nack, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rd_data", rd_data, 8'h00);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_wr_req", wr_req, 0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);

        // write 0xAA to 0x50, slave ACKs everything
        wr_data = 8'hAA;
        s0 = n_start; p0 = n_stop; w0 = wr_cnt;
        run_txn(7'h50, 1'b0, 4'd1, 0, 1'b0, cyc);
        check_val("wr1_cycles", cyc, 308);
        check_val("wr1_addr_frame", frames[0], 9'h140);
        check_val("wr1_data_frame", frames[1], 9'h154);
        check_val("wr1_wr_req_cnt", wr_cnt - w0, 1);
        check_val("wr1_nack", nack, 0);
        check_val("wr1_busy_end", busy, 0);
        check_val("wr1_starts", n_start - s0, 1);
        check_val("wr1_stops", n_stop - p0, 1);
        repeat (5) @(posedge clk);

        // address NACK
        ack_addr = 1'b0;
        p0 = n_stop; w0 = wr_cnt;
        run_txn(7'h50, 1'b0, 4'd1, 0, 1'b0, cyc);
        check_val("nak_cycles", cyc, 164);
        check_val("nak_addr_frame", frames[0], 9'h141);
        check_val("nak_wr_req_cnt", wr_cnt - w0, 0);
        check_val("nak_nack", nack, 1);
        check_val("nak_stops", n_stop - p0, 1);
        ack_addr = 1'b1;
        repeat (5) @(posedge clk);

        // two-byte read
        nrd = 2;
        r0 = rd_cnt;
        run_txn(7'h50, 1'b1, 4'd2, 0, 1'b0, cyc);
        check_val("rd_cycles", cyc, 452);
        check_val("rd_valid_cnt", rd_cnt - r0, 2);
        check_val("rd_byte0", rd_log[r0 % 16], 8'h3C);
        check_val("rd_byte1", rd_log[(r0 + 1) % 16], 8'hC3);
        check_val("rd_addr_frame", frames[0], 9'h142);
        check_val("rd_frame1_ack", frames[1], 9'h078);
        check_val("rd_frame2_nack", frames[2], 9'h187);
        check_val("rd_nack_cleared", nack, 0);
        nrd = 0;
        repeat (5) @(posedge clk);

        // slave stretches SCL for 20 clocks in address bit 3
        stretch_en = 1'b1;
        s0 = n_start; p0 = n_stop;
        run_txn(7'h50, 1'b0, 4'd1, 0, 1'b0, cyc);
        check_val("str_cycles", cyc, 328);
        check_val("str_addr_frame", frames[0], 9'h140);
        check_val("str_data_frame", frames[1], 9'h154);
        check_val("str_starts", n_start - s0, 1);
        check_val("str_stops", n_stop - p0, 1);
        stretch_en = 1'b0;
        repeat (5) @(posedge clk);

        // address-only probe with an extra start while busy
        p0 = n_stop; w0 = wr_cnt; r0 = rd_cnt;
        run_txn(7'h50, 1'b0, 4'd0, 0, 1'b1, cyc);
        check_val("prb_cycles", cyc, 164);
        check_val("prb_addr_frame", frames[0], 9'h140);
        check_val("prb_wr_req_cnt", wr_cnt - w0, 0);
        check_val("prb_rd_valid_cnt", rd_cnt - r0, 0);
        check_val("prb_nack", nack, 0);
        check_val("prb_stops", n_stop - p0, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_val("done_cycle_start_ignored", busy, 0);
        check_val("done_one_cycle", done, 0);
        repeat (5) @(posedge clk);

        // reset in the middle of a write data byte
        run_txn(7'h50, 1'b0, 4'd2, 170, 1'b0, cyc);
        reset = 1'b1;
        #1;
        check_val("mid_rst_scl_oe", scl_oe, 0);
        check_val("mid_rst_sda_oe", sda_oe, 0);
        check_val("mid_rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        w0 = wr_cnt;
        run_txn(7'h50, 1'b0, 4'd1, 0, 1'b0, cyc);
        check_val("post_rst_cycles", cyc, 308);
        check_val("post_rst_addr_frame", frames[0], 9'h140);
        check_val("post_rst_data_frame", frames[1], 9'h154);
        check_val("post_rst_wr_req_cnt", wr_cnt - w0, 1);
        check_val("post_rst_nack", nack, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
